// File: rtl/io_unit.sv
// io_unit: memory-mapped IO block behind the CPU data-memory port.
//
// Decodes loads/stores with dataAddr[15]=1 (register index dataAddr[6:2]),
// holds the sort-benchmark control state, lamp/LED registers and the OLED
// refresh handshake, debounces the front-panel switches and builds the
// 32-bit digit word for the dynamic display.
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   dataAddr        - CPU data address (IO when bit 15 set)
//   dataWrEnable    - CPU store strobe
//   dataWrData      - CPU store data
//   ioRdData        - combinational read data for dataAddr
//   sortStartSw,
//   ceSw, cpSw, chSw- raw asynchronous switch inputs
//   oledReady       - OLED controller idle
//   oledUpdate      - one-cycle OLED refresh request
//   lamp            - lamp register
//   ledOut          - four 8-bit digit fields for the dynamic display
//   sortRunning     - high while the sort FSM is RUNNING
module io_unit #(
    parameter logic [27:0] DEBOUNCE_COUNT = 28'h3000,
    parameter int unsigned CYCLE_WIDTH    = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] dataAddr,
    input  logic        dataWrEnable,
    input  logic [31:0] dataWrData,
    output logic [31:0] ioRdData,
    input  logic        sortStartSw,
    input  logic        ceSw,
    input  logic        cpSw,
    input  logic        chSw,
    input  logic        oledReady,
    output logic        oledUpdate,
    output logic [7:0]  lamp,
    output logic [31:0] ledOut,
    output logic        sortRunning
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] RUNNING  = 2'd1;
    localparam logic [1:0] FINISHED = 2'd2;

    logic                   io_sel;
    logic [4:0]             reg_idx;
    logic                   wr;
    logic [3:0]             sw_raw;
    logic [3:0]             sync1;
    logic [3:0]             sync2;
    logic [3:0]             deb;
    logic                   start_prev;
    logic                   start_edge;
    logic                   finish_req;
    logic [1:0]             state;
    logic [CYCLE_WIDTH-1:0] cycle_count;
    logic [CYCLE_WIDTH-1:0] sort_count;
    logic                   led_ctrl;
    logic [31:0]            led_user;
    logic [31:0]            cycle_ext;
    logic [31:0]            sort_ext;
    logic                   unused_addr;

    assign io_sel      = dataAddr[15];
    assign reg_idx     = dataAddr[6:2];
    assign wr          = dataWrEnable & io_sel;
    assign sw_raw      = {chSw, cpSw, ceSw, sortStartSw};
    assign start_edge  = deb[0] & ~start_prev;
    assign finish_req  = wr && (reg_idx == 5'h00) && dataWrData[0];
    assign sortRunning = (state == RUNNING);
    assign unused_addr = ^{dataAddr[14:7], dataAddr[1:0]};

    // Two-flop synchronizers for all four switches.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= sw_raw;
            sync2 <= sync1;
        end
    end

    // Level follows the synchronized input only after DEBOUNCE_COUNT
    // consecutive disagreeing samples; the flip happens on the edge that
    // would bring the count to DEBOUNCE_COUNT.
    for (genvar g = 0; g < 4; g++) begin : g_deb
        logic        level;
        logic [27:0] cnt;
        always_ff @(posedge clk) begin
            if (rst) begin
                level <= 1'b0;
                cnt   <= '0;
            end else if (sync2[g] == level) begin
                cnt <= '0;
            end else if (cnt == DEBOUNCE_COUNT - 28'd1) begin
                level <= sync2[g];
                cnt   <= '0;
            end else begin
                cnt <= cnt + 28'd1;
            end
        end
        assign deb[g] = level;
    end

    // Sort FSM and cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cycle_count <= '0;
            start_prev  <= 1'b0;
        end else begin
            start_prev <= deb[0];
            case (state)
                IDLE: begin
                    if (start_edge) begin
                        state       <= RUNNING;
                        cycle_count <= '0;
                    end
                end
                RUNNING: begin
                    if (finish_req) begin
                        state <= FINISHED;
                    end else if (cycle_count != '1) begin
                        cycle_count <= cycle_count + CYCLE_WIDTH'(1);
                    end
                end
                FINISHED: begin
                    if (start_edge) begin
                        state       <= RUNNING;
                        cycle_count <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Writable registers, OLED pulse and registered display word.
    always_ff @(posedge clk) begin
        if (rst) begin
            sort_count <= '0;
            lamp       <= '0;
            led_ctrl   <= 1'b0;
            led_user   <= '0;
            oledUpdate <= 1'b0;
            ledOut     <= '0;
        end else begin
            oledUpdate <= wr && (reg_idx == 5'h09) && oledReady;
            ledOut     <= led_ctrl ? led_user : {cycle_count[15:0], sort_count[15:0]};
            if (wr) begin
                case (reg_idx)
                    5'h01:   sort_count <= dataWrData[CYCLE_WIDTH-1:0];
                    5'h02:   lamp       <= dataWrData[7:0];
                    5'h03:   led_ctrl   <= dataWrData[0];
                    5'h04:   led_user   <= dataWrData;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        cycle_ext                  = '0;
        cycle_ext[CYCLE_WIDTH-1:0] = cycle_count;
        sort_ext                   = '0;
        sort_ext[CYCLE_WIDTH-1:0]  = sort_count;
    end

    always_comb begin
        ioRdData = '0;
        if (io_sel) begin
            case (reg_idx)
                5'h00:   ioRdData = {31'b0, state == FINISHED};
                5'h01:   ioRdData = sort_ext;
                5'h02:   ioRdData = {24'b0, lamp};
                5'h03:   ioRdData = {31'b0, led_ctrl};
                5'h04:   ioRdData = led_user;
                5'h08:   ioRdData = {31'b0, oledReady};
                5'h10:   ioRdData = {31'b0, state == RUNNING};
                5'h11:   ioRdData = {31'b0, deb[1]};
                5'h12:   ioRdData = {31'b0, deb[2]};
                5'h13:   ioRdData = {31'b0, deb[3]};
                5'h14:   ioRdData = cycle_ext;
                default: ioRdData = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_io_unit.sv
// tb_io_unit: self-checking bench for io_unit with DEBOUNCE_COUNT=4.
// A behavioural model (register file, sort FSM, sliding-window debouncer)
// predicts every output each cycle; directed steps add fixed-value checks.
module tb_io_unit;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] dataAddr;
    logic        dataWrEnable;
    logic [31:0] dataWrData;
    logic [31:0] ioRdData;
    logic        sortStartSw, ceSw, cpSw, chSw;
    logic        oledReady;
    logic        oledUpdate;
    logic [7:0]  lamp;
    logic [31:0] ledOut;
    logic        sortRunning;

    io_unit #(
        .DEBOUNCE_COUNT(28'd4),
        .CYCLE_WIDTH   (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .dataAddr    (dataAddr),
        .dataWrEnable(dataWrEnable),
        .dataWrData  (dataWrData),
        .ioRdData    (ioRdData),
        .sortStartSw (sortStartSw),
        .ceSw        (ceSw),
        .cpSw        (cpSw),
        .chSw        (chSw),
        .oledReady   (oledReady),
        .oledUpdate  (oledUpdate),
        .lamp        (lamp),
        .ledOut      (ledOut),
        .sortRunning (sortRunning)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model state: 0 idle, 1 running, 2 finished
    int        m_state;
    bit [31:0] m_cc, m_sc, m_leduser, m_ledout;
    bit [7:0]  m_lamp;
    bit        m_ledctrl, m_oled, m_prev;
    bit        m_deb [4];
    bit        raw_q [4][$];
    bit        syn_q [4][$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit [31:0] model_read(input bit [15:0] a, input bit ready);
        if (!a[15]) return 32'h0;
        case (a[6:2])
            5'h00:   return {31'b0, m_state == 2};
            5'h01:   return m_sc;
            5'h02:   return {24'b0, m_lamp};
            5'h03:   return {31'b0, m_ledctrl};
            5'h04:   return m_leduser;
            5'h08:   return {31'b0, ready};
            5'h10:   return {31'b0, m_state == 1};
            5'h11:   return {31'b0, m_deb[1]};
            5'h12:   return {31'b0, m_deb[2]};
            5'h13:   return {31'b0, m_deb[3]};
            5'h14:   return m_cc;
            default: return 32'h0;
        endcase
    endfunction

    // Advance the model by one clock edge using the inputs present now.
    task automatic model_edge();
        bit [3:0]  raw;
        bit        wr, se, fin, s, all;
        bit [4:0]  idx;
        bit [31:0] new_ledout;
        int        n;
        raw = {chSw, cpSw, ceSw, sortStartSw};
        if (rst) begin
            m_state = 0; m_cc = 0; m_sc = 0; m_leduser = 0; m_ledout = 0;
            m_lamp = 0; m_ledctrl = 0; m_oled = 0; m_prev = 0;
            for (int i = 0; i < 4; i++) begin
                m_deb[i] = 0;
                raw_q[i].delete();
                syn_q[i].delete();
            end
            return;
        end
        wr  = dataWrEnable && dataAddr[15];
        idx = dataAddr[6:2];
        se  = m_deb[0] && !m_prev;
        fin = wr && idx == 5'h00 && dataWrData[0];
        new_ledout = m_ledctrl ? m_leduser : {m_cc[15:0], m_sc[15:0]};
        case (m_state)
            0: if (se) begin m_state = 1; m_cc = 0; end
            1: begin
                if (fin) m_state = 2;
                else if (m_cc != 32'hFFFF_FFFF) m_cc = m_cc + 1;
            end
            default: if (se) begin m_state = 1; m_cc = 0; end
        endcase
        if (wr) begin
            case (idx)
                5'h01: m_sc      = dataWrData;
                5'h02: m_lamp    = dataWrData[7:0];
                5'h03: m_ledctrl = dataWrData[0];
                5'h04: m_leduser = dataWrData;
                default: ;
            endcase
        end
        m_oled   = wr && idx == 5'h09 && oledReady;
        m_prev   = m_deb[0];
        m_ledout = new_ledout;
        // Synchronized value seen at this edge is the raw level sampled two
        // edges ago; the level flips once the last D such values all differ.
        for (int i = 0; i < 4; i++) begin
            n = raw_q[i].size();
            s = (n >= 2) ? raw_q[i][n-2] : 1'b0;
            syn_q[i].push_back(s);
            n = syn_q[i].size();
            if (n >= D) begin
                all = 1;
                for (int j = n - D; j < n; j++)
                    if (syn_q[i][j] == m_deb[i]) all = 0;
                if (all) m_deb[i] = s;
            end
            while (syn_q[i].size() > D) void'(syn_q[i].pop_front());
            raw_q[i].push_back(raw[i]);
            while (raw_q[i].size() > 2) void'(raw_q[i].pop_front());
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        chk("ledOut", ledOut, m_ledout);
        chk("lamp", {24'b0, lamp}, {24'b0, m_lamp});
        chk("oledUpdate", {31'b0, oledUpdate}, {31'b0, m_oled});
        chk("sortRunning", {31'b0, sortRunning}, {31'b0, m_state == 1});
        chk("ioRdData", ioRdData, model_read(dataAddr, oledReady));
    endtask

    task automatic wr_reg(input logic [4:0] idx, input logic [31:0] d);
        dataAddr     = {1'b1, 8'h00, idx, 2'b00};
        dataWrData   = d;
        dataWrEnable = 1'b1;
        tick();
        dataWrEnable = 1'b0;
    endtask

    task automatic rd(input logic [4:0] idx, input logic [31:0] exp, input string tag);
        dataAddr     = {1'b1, 8'h00, idx, 2'b00};
        dataWrEnable = 1'b0;
        #1;
        chk(tag, ioRdData, exp);
    endtask

    task automatic set_fin_write();
        dataAddr     = 16'h8000;
        dataWrData   = 32'h1;
        dataWrEnable = 1'b1;
    endtask

    logic [4:0] idx_tab [14] = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h08, 5'h09,
                                 5'h10, 5'h11, 5'h12, 5'h13, 5'h14, 5'h05, 5'h1F};

    initial begin
        int  k;
        bit  found;
        rst = 1'b1; dataAddr = '0; dataWrEnable = 1'b0; dataWrData = '0;
        sortStartSw = 1'b0; ceSw = 1'b0; cpSw = 1'b0; chSw = 1'b0; oledReady = 1'b0;

        // Reset with inputs toggling
        for (int c = 0; c < 2; c++) begin
            sortStartSw = ~sortStartSw; ceSw = ~ceSw; cpSw = ~cpSw; chSw = ~chSw;
            oledReady = ~oledReady; dataWrEnable = 1'b1;
            dataAddr = 16'h8000 | 16'(((c == 0) ? 9 : 2) << 2); dataWrData = $urandom;
            tick();
        end
        rst = 1'b0; dataWrEnable = 1'b0; oledReady = 1'b0;
        sortStartSw = 1'b0; ceSw = 1'b0; cpSw = 1'b0; chSw = 1'b0;
        chk("rst_ledOut", ledOut, 32'h0);
        chk("rst_lamp", {24'b0, lamp}, 32'h0);
        chk("rst_oled", {31'b0, oledUpdate}, 32'h0);
        chk("rst_running", {31'b0, sortRunning}, 32'h0);
        rd(5'h00, 32'h0, "rst_rd00");
        rd(5'h14, 32'h0, "rst_rd14");

        // Start / finish
        sortStartSw = 1'b1;
        k = 0;
        while (k < 20 && !sortRunning) begin tick(); k++; end
        chk("start_latency", 32'(k), 32'd7);
        rd(5'h14, 32'd0, "cc_at_start");
        repeat (100) tick();
        wr_reg(5'h00, 32'h1);
        rd(5'h00, 32'h1, "finished_flag");
        rd(5'h14, 32'd100, "cc_frozen");
        repeat (5) tick();
        rd(5'h14, 32'd100, "cc_still_frozen");
        chk("led_cycle_field", {16'h0, ledOut[31:16]}, 32'd100);

        // Debounce: short pulse rejected, long pulse accepted after 6 edges
        dataAddr = 16'h8000 | 16'(5'h11 << 2);
        ceSw = 1'b1;
        for (int c = 0; c < 13; c++) begin
            if (c == 3) ceSw = 1'b0;
            tick();
            chk("ce_glitch", ioRdData, 32'h0);
        end
        ceSw = 1'b1; found = 0; k = 0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (!found && ioRdData[0]) begin found = 1; k = c; end
        end
        chk("ce_latency", 32'(k), 32'd6);
        ceSw = 1'b0;
        repeat (8) tick();

        // Simultaneous start edge and finish write
        sortStartSw = 1'b0;
        repeat (8) tick();
        sortStartSw = 1'b1;
        k = 0;
        while (k < 20 && !sortRunning) begin tick(); k++; end
        chk("restart_latency", 32'(k), 32'd7);
        sortStartSw = 1'b0;
        repeat (8) tick();
        sortStartSw = 1'b1;
        repeat (6) tick();
        set_fin_write();
        tick();
        dataWrEnable = 1'b0;
        chk("coinc_running", {31'b0, sortRunning}, 32'h0);
        rd(5'h00, 32'h1, "coinc_run_fin");
        sortStartSw = 1'b0;
        repeat (8) tick();
        sortStartSw = 1'b1;
        repeat (6) tick();
        set_fin_write();
        tick();
        dataWrEnable = 1'b0;
        chk("coinc_finished", {31'b0, sortRunning}, 32'h1);
        rd(5'h14, 32'h0, "coinc_cc_zero");
        sortStartSw = 1'b0;

        // OLED handshake
        oledReady = 1'b1;
        wr_reg(5'h09, 32'h1);
        chk("oled_pulse", {31'b0, oledUpdate}, 32'h1);
        tick();
        chk("oled_single", {31'b0, oledUpdate}, 32'h0);
        oledReady = 1'b0;
        wr_reg(5'h09, 32'h1);
        chk("oled_dropped", {31'b0, oledUpdate}, 32'h0);
        oledReady = 1'b1;
        wr_reg(5'h09, 32'h1);
        wr_reg(5'h09, 32'h1);
        chk("oled_b2b", {31'b0, oledUpdate}, 32'h1);
        tick();

        // Registers, LED select and non-IO writes
        wr_reg(5'h02, 32'h1A5);
        chk("lamp_a5", {24'b0, lamp}, 32'hA5);
        wr_reg(5'h04, 32'hDEAD_BEEF);
        wr_reg(5'h03, 32'h1);
        tick();
        chk("led_user", ledOut, 32'hDEAD_BEEF);
        dataAddr = 16'h0008; dataWrData = 32'h33; dataWrEnable = 1'b1;
        tick();
        dataAddr = 16'h0010; dataWrData = 32'h0;
        tick();
        dataWrEnable = 1'b0;
        chk("nonio_lamp", {24'b0, lamp}, 32'hA5);
        chk("nonio_led", ledOut, 32'hDEAD_BEEF);
        rd(5'h04, 32'hDEAD_BEEF, "nonio_leduser");

        // Randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 11) == 0) begin
                case ($urandom_range(0, 3))
                    0: sortStartSw = ~sortStartSw;
                    1: ceSw = ~ceSw;
                    2: cpSw = ~cpSw;
                    default: chSw = ~chSw;
                endcase
            end
            oledReady    = $urandom_range(0, 1);
            dataWrEnable = ($urandom_range(0, 99) < 30);
            dataAddr     = {($urandom_range(0, 9) != 0), 8'($urandom),
                            idx_tab[$urandom_range(0, 13)], 2'($urandom)};
            dataWrData   = $urandom;
            tick();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
